// File: rtl/or_gate_pin_tester_if.sv
// Pin bundle between the OR-gate tester, its board-level controller and the
// external triple 2-input OR package under test.
interface or_gate_pin_tester_if;
   logic       START;
   logic       Y1;
   logic       Y2;
   logic       Y3;
   logic       A1;
   logic       B1;
   logic       A2;
   logic       B2;
   logic       A3;
   logic       B3;
   logic       BUSY;
   logic       DONE;
   logic       PASS;
   logic [2:0] FAIL_MASK;
   logic [3:0] ERR_COUNT;

   modport slave (
      input  START, Y1, Y2, Y3,
      output A1, B1, A2, B2, A3, B3, BUSY, DONE, PASS, FAIL_MASK, ERR_COUNT
   );

   modport master (
      output START, Y1, Y2, Y3,
      input  A1, B1, A2, B2, A3, B3, BUSY, DONE, PASS, FAIL_MASK, ERR_COUNT
   );
endinterface

// File: rtl/or_gate_pin_tester.sv
// In-circuit tester for a triple 2-input OR package: steps 12 A/B vectors,
// compares the synchronized Y pins against A|B and reports per-gate results.
module or_gate_pin_tester #(
   parameter int unsigned SETTLE = 2
) (
   input  logic                  CLK,
   input  logic                  CLR_N,
   or_gate_pin_tester_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);
   localparam logic [3:0] K_LAST   = 4'd11;

   state_t     r_state;
   logic [3:0] r_cnt;
   logic [3:0] r_k;
   logic [2:0] r_a;
   logic [2:0] r_b;
   logic       r_busy;
   logic       r_done;
   logic       r_pass;
   logic [2:0] r_fail_mask;
   logic [3:0] r_err_count;
   logic [2:0] r_y_s1;
   logic [2:0] r_y_s2;

   state_t     w_state_n;
   logic [3:0] w_cnt_n;
   logic [3:0] w_k_n;
   logic [2:0] w_a_n;
   logic [2:0] w_b_n;
   logic       w_busy_n;
   logic       w_done_n;
   logic       w_pass_n;
   logic [2:0] w_fail_mask_n;
   logic [3:0] w_err_count_n;

   logic [2:0] w_gsel;
   logic       w_exp;
   logic       w_y;
   logic       w_miss;
   logic [3:0] w_err_inc;
   logic [5:0] w_vec_first;
   logic [5:0] w_vec_next;

   // Vector k selects gate k[3:2]; within a gate (A,B) runs 11,01,10,00.
   function automatic logic [5:0] vec_ab(input logic [3:0] k);
      logic [2:0] sel;
      logic [2:0] a;
      logic [2:0] b;
      case (k[3:2])
         2'd0:    sel = 3'b001;
         2'd1:    sel = 3'b010;
         default: sel = 3'b100;
      endcase
      a = sel & {3{~k[0]}};
      b = sel & {3{~k[1]}};
      return {a, b};
   endfunction

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         r_y_s1 <= '0;
         r_y_s2 <= '0;
      end else begin
         r_y_s1 <= {bus.Y3, bus.Y2, bus.Y1};
         r_y_s2 <= r_y_s1;
      end
   end

   always_comb begin
      case (r_k[3:2])
         2'd0:    w_gsel = 3'b001;
         2'd1:    w_gsel = 3'b010;
         default: w_gsel = 3'b100;
      endcase
   end

   assign w_exp       = |((r_a | r_b) & w_gsel);
   assign w_y         = |(r_y_s2 & w_gsel);
   assign w_miss      = (w_y != w_exp);
   assign w_err_inc   = r_err_count + {3'b000, w_miss};
   assign w_vec_first = vec_ab(4'd0);
   assign w_vec_next  = vec_ab(r_k + 4'd1);

   always_comb begin
      w_state_n     = r_state;
      w_cnt_n       = r_cnt;
      w_k_n         = r_k;
      w_a_n         = r_a;
      w_b_n         = r_b;
      w_busy_n      = r_busy;
      w_done_n      = 1'b0;
      w_pass_n      = r_pass;
      w_fail_mask_n = r_fail_mask;
      w_err_count_n = r_err_count;

      case (r_state)
         ST_IDLE: begin
            if (bus.START) begin
               w_fail_mask_n = '0;
               w_err_count_n = '0;
               w_pass_n      = 1'b0;
               w_busy_n      = 1'b1;
               w_k_n         = '0;
               w_cnt_n       = '0;
               {w_a_n, w_b_n} = w_vec_first;
               w_state_n     = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            if (r_cnt == CNT_LAST) begin
               w_state_n = ST_SAMPLE;
            end else begin
               w_cnt_n = r_cnt + 4'd1;
            end
         end

         ST_SAMPLE: begin
            if (w_miss) begin
               w_fail_mask_n = r_fail_mask | w_gsel;
               w_err_count_n = w_err_inc;
            end
            if (r_k != K_LAST) begin
               w_k_n          = r_k + 4'd1;
               {w_a_n, w_b_n} = w_vec_next;
               w_cnt_n        = '0;
               w_state_n      = ST_SETTLE;
            end else begin
               w_a_n     = '0;
               w_b_n     = '0;
               w_busy_n  = 1'b0;
               // PASS must reflect the count including this final compare.
               w_pass_n  = (w_err_inc == 4'd0);
               w_done_n  = 1'b1;
               w_state_n = ST_FINISH;
            end
         end

         ST_FINISH: begin
            w_state_n = ST_IDLE;
         end

         default: begin
            w_state_n = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_k         <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail_mask <= '0;
         r_err_count <= '0;
      end else begin
         r_state     <= w_state_n;
         r_cnt       <= w_cnt_n;
         r_k         <= w_k_n;
         r_a         <= w_a_n;
         r_b         <= w_b_n;
         r_busy      <= w_busy_n;
         r_done      <= w_done_n;
         r_pass      <= w_pass_n;
         r_fail_mask <= w_fail_mask_n;
         r_err_count <= w_err_count_n;
      end
   end

   assign bus.A1        = r_a[0];
   assign bus.B1        = r_b[0];
   assign bus.A2        = r_a[1];
   assign bus.B2        = r_b[1];
   assign bus.A3        = r_a[2];
   assign bus.B3        = r_b[2];
   assign bus.BUSY      = r_busy;
   assign bus.DONE      = r_done;
   assign bus.PASS      = r_pass;
   assign bus.FAIL_MASK = r_fail_mask;
   assign bus.ERR_COUNT = r_err_count;

endmodule

// File: tb/tb_or_gate_pin_tester.sv
// Self-checking bench: a faultable OR-gate model on the Y pins, expected
// vectors and results queued at START and popped as the DUT produces them.
module tb_or_gate_pin_tester;

   typedef struct {
      logic [2:0] fm;
      logic [3:0] ec;
      logic       pass;
   } res_t;

   logic CLK;
   logic CLR_N;
   logic start;
   logic sel;
   int   mode;

   int   n_vec;
   int   n_err;

   logic [5:0] q_vec[$];
   res_t       q_res[$];
   logic [1:0] pat [4] = '{2'b11, 2'b01, 2'b10, 2'b00};

   logic [2:0] o_a, o_b, o_fm;
   logic [3:0] o_ec;
   logic       o_busy, o_done, o_pass;

   or_gate_pin_tester_if bus();
   or_gate_pin_tester_if bus4();

   or_gate_pin_tester #(.SETTLE(2)) dut (
      .CLK   (CLK),
      .CLR_N (CLR_N),
      .bus   (bus)
   );

   or_gate_pin_tester #(.SETTLE(4)) dut4 (
      .CLK   (CLK),
      .CLR_N (CLR_N),
      .bus   (bus4)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Modes: 0 good, 1 Y2 stuck-0, 2 Y3 stuck-1, 3 Y1=A&B, 4 Y1 stuck-0.
   function automatic logic y_model(input int m, input int g, input logic a, input logic b);
      if (m == 1 && g == 1) return 1'b0;
      if (m == 2 && g == 2) return 1'b1;
      if (m == 3 && g == 0) return a & b;
      if (m == 4 && g == 0) return 1'b0;
      return a | b;
   endfunction

   assign bus.START  = start & ~sel;
   assign bus4.START = start & sel;

   always_comb begin
      bus.Y1  = y_model(mode, 0, bus.A1, bus.B1);
      bus.Y2  = y_model(mode, 1, bus.A2, bus.B2);
      bus.Y3  = y_model(mode, 2, bus.A3, bus.B3);
      bus4.Y1 = y_model(mode, 0, bus4.A1, bus4.B1);
      bus4.Y2 = y_model(mode, 1, bus4.A2, bus4.B2);
      bus4.Y3 = y_model(mode, 2, bus4.A3, bus4.B3);
   end

   always_comb begin
      if (sel) begin
         o_a    = {bus4.A3, bus4.A2, bus4.A1};
         o_b    = {bus4.B3, bus4.B2, bus4.B1};
         o_busy = bus4.BUSY;
         o_done = bus4.DONE;
         o_pass = bus4.PASS;
         o_fm   = bus4.FAIL_MASK;
         o_ec   = bus4.ERR_COUNT;
      end else begin
         o_a    = {bus.A3, bus.A2, bus.A1};
         o_b    = {bus.B3, bus.B2, bus.B1};
         o_busy = bus.BUSY;
         o_done = bus.DONE;
         o_pass = bus.PASS;
         o_fm   = bus.FAIL_MASK;
         o_ec   = bus.ERR_COUNT;
      end
   end

   // Starts a run from a negedge, checks every cycle through E+1 (E+2 if poked).
   task automatic run_check(input int s, input int m, input bit hold, input bit poke);
      res_t       r;
      res_t       got;
      logic [5:0] cur;
      logic [2:0] va, vb;
      logic       a, b, y;
      int         g, v;
      mode = m;
      r.fm = '0;
      r.ec = '0;
      for (int k = 0; k < 12; k++) begin
         g = k / 4;
         v = k % 4;
         a = pat[v][1];
         b = pat[v][0];
         va = '0;
         vb = '0;
         va[g] = a;
         vb[g] = b;
         q_vec.push_back({va, vb});
         y = y_model(m, g, a, b);
         if (y != (a | b)) begin
            r.fm[g] = 1'b1;
            r.ec    = r.ec + 4'd1;
         end
      end
      r.pass = (r.ec == 4'd0);
      q_res.push_back(r);
      cur = '0;

      start = 1'b1;
      @(posedge CLK);
      #1;
      if (!hold) start = 1'b0;
      for (int t = 0; t < 12 * (s + 1); t++) begin
         @(negedge CLK);
         if (poke && t == 5) start = 1'b1;
         if (poke && t == 6) start = 1'b0;
         if (t % (s + 1) == 0) cur = q_vec.pop_front();
         n_vec++;
         if ({o_a, o_b} !== cur) begin
            n_err++;
            $display("FAIL vector t=%0d: got A=%b B=%b, want A=%b B=%b", t, o_a, o_b, cur[5:3], cur[2:0]);
         end
         n_vec++;
         if ({o_busy, o_done} !== 2'b10) begin
            n_err++;
            $display("FAIL busy_phase t=%0d: got BUSY=%b DONE=%b, want 1 0", t, o_busy, o_done);
         end
         if (t == 0) begin
            n_vec++;
            if ({o_fm, o_ec, o_pass} !== 8'h00) begin
               n_err++;
               $display("FAIL clear_on_start: got FM=%b EC=%0d PASS=%b, want 0 0 0", o_fm, o_ec, o_pass);
            end
         end
      end

      @(negedge CLK);
      got = q_res.pop_front();
      n_vec++;
      if ({o_busy, o_done, o_a, o_b} !== 8'b01_000_000) begin
         n_err++;
         $display("FAIL finish_edge: got BUSY=%b DONE=%b A=%b B=%b, want 0 1 000 000", o_busy, o_done, o_a, o_b);
      end
      n_vec++;
      if ({o_fm, o_ec, o_pass} !== {got.fm, got.ec, got.pass}) begin
         n_err++;
         $display("FAIL results: got FM=%b EC=%0d PASS=%b, want FM=%b EC=%0d PASS=%b",
                  o_fm, o_ec, o_pass, got.fm, got.ec, got.pass);
      end
      if (poke) start = 1'b1;

      @(negedge CLK);
      if (poke) start = 1'b0;
      n_vec++;
      if ({o_busy, o_done} !== 2'b00) begin
         n_err++;
         $display("FAIL done_single: got BUSY=%b DONE=%b, want 0 0", o_busy, o_done);
      end
      n_vec++;
      if ({o_fm, o_ec, o_pass} !== {got.fm, got.ec, got.pass}) begin
         n_err++;
         $display("FAIL results_hold: got FM=%b EC=%0d PASS=%b, want FM=%b EC=%0d PASS=%b",
                  o_fm, o_ec, o_pass, got.fm, got.ec, got.pass);
      end

      if (poke) begin
         @(negedge CLK);
         n_vec++;
         if (o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_ignored: got BUSY=%b, want 0", o_busy);
         end
      end
   endtask

   task automatic check_all_zero(input string name);
      n_vec++;
      if ({o_a, o_b, o_busy, o_done, o_pass, o_fm, o_ec} !== 16'h0000) begin
         n_err++;
         $display("FAIL %s: got A=%b B=%b BUSY=%b DONE=%b PASS=%b FM=%b EC=%0d, want all 0",
                  name, o_a, o_b, o_busy, o_done, o_pass, o_fm, o_ec);
      end
   endtask

   task automatic test_reset();
      CLR_N = 1'b0;
      #12;
      sel = 1'b0;
      #1 check_all_zero("reset_dut2");
      sel = 1'b1;
      #1 check_all_zero("reset_dut4");
      sel = 1'b0;
      @(negedge CLK);
      CLR_N = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_good();
      sel = 1'b0;
      run_check(2, 0, 1'b0, 1'b0);
   endtask

   task automatic test_faults();
      sel = 1'b0;
      run_check(2, 1, 1'b0, 1'b0);
      run_check(2, 2, 1'b0, 1'b0);
      run_check(2, 3, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midrun();
      sel = 1'b0;
      mode = 4;
      start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      repeat (10) @(posedge CLK);
      #2 CLR_N = 1'b0;
      #1 check_all_zero("midrun_reset");
      @(negedge CLK);
      CLR_N = 1'b1;
      @(negedge CLK);
      run_check(2, 4, 1'b0, 1'b0);
   endtask

   task automatic test_start_ignored();
      sel = 1'b0;
      run_check(2, 0, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      sel = 1'b0;
      run_check(2, 1, 1'b1, 1'b0);
      run_check(2, 0, 1'b0, 1'b0);
   endtask

   task automatic test_settle4();
      sel = 1'b1;
      run_check(4, 0, 1'b0, 1'b0);
      sel = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      start = 1'b0;
      sel   = 1'b0;
      mode  = 0;
      CLR_N = 1'b0;
      test_reset();
      test_good();
      test_faults();
      test_reset_midrun();
      test_start_ignored();
      test_back_to_back();
      test_settle4();
      repeat (2) @(negedge CLK);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
